// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART responder. Receives a fixed-length request
// frame into byte registers and transmits four CPU-written result digits as
// ASCII, most significant first, followed by LF. Serial format 8N1, LSB first.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_LEN    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [5:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [5:0] ADDR_STATUS = 6'h14;
  localparam logic [5:0] ADDR_UNITS  = 6'h18;
  localparam logic [5:0] ADDR_TENS   = 6'h1C;
  localparam logic [5:0] ADDR_HUNDS  = 6'h20;
  localparam logic [5:0] ADDR_THOUS  = 6'h24;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Digit to ASCII; anything that is not a decimal digit is shown as '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [7:0] d);
    if (d > 8'd9) return 8'h3F;
    else          return 8'h30 + {4'h0, d[3:0]};
  endfunction

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic byte_done_s;
  logic [7:0] rx_byte_q [FRAME_LEN];
  logic [7:0] rx_byte_d [FRAME_LEN];
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d, idx_base_s;
  logic rx_ready_q, rx_ready_d, ready_base_s;
  logic overrun_q, overrun_d;
  logic [7:0] res_q [4];
  logic [7:0] res_d [4];
  tx_state_e tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [2:0] tx_sel_q, tx_sel_d;
  logic [7:0] tx_buf_q [5];
  logic [7:0] tx_buf_d [5];
  logic tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic wr_s, launch_s;
  logic unused_wdata_s;

  assign unused_wdata_s = ^wdata[31:8];
  assign wr_s        = sel & we;
  assign launch_s    = wr_s && (addr == ADDR_THOUS) && !tx_busy_q;
  // A launch restarts frame assembly in the same edge, so it overrides rx_ready.
  assign ready_base_s = launch_s ? 1'b0 : rx_ready_q;
  assign idx_base_s   = launch_s ? IDX_ZERO : rx_idx_q;
  assign tx = tx_q;

  // Two-flop synchroniser on rx plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX bit-timing FSM: mid-bit start check, 8 data samples, stop-bit check.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_done_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
        else                         rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          if (rx_sync_q) rx_state_d = RX_IDLE;
          else           rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = CNT_ZERO;
          rx_state_d  = RX_IDLE;
          byte_done_s = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame assembly, overrun tracking and result-digit register writes.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) rx_byte_d[i] = rx_byte_q[i];
    for (int i = 0; i < 4; i++) res_d[i] = res_q[i];
    rx_ready_d = ready_base_s;
    rx_idx_d   = idx_base_s;
    if (wr_s && (addr == ADDR_STATUS)) overrun_d = 1'b0;
    else                               overrun_d = overrun_q;
    if (byte_done_s) begin
      if (ready_base_s) begin
        overrun_d = 1'b1;
      end else begin
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (IDX_W'(i) == idx_base_s) rx_byte_d[i] = rx_shift_q;
          else                         rx_byte_d[i] = rx_byte_q[i];
        end
        if (idx_base_s == IDX_LAST) begin
          rx_ready_d = 1'b1;
          rx_idx_d   = IDX_ZERO;
        end else begin
          rx_idx_d   = idx_base_s + IDX_ONE;
        end
      end
    end else begin
      rx_ready_d = ready_base_s;
    end
    if (wr_s) begin
      case (addr)
        ADDR_UNITS: res_d[0] = wdata[7:0];
        ADDR_TENS:  res_d[1] = wdata[7:0];
        ADDR_HUNDS: res_d[2] = wdata[7:0];
        ADDR_THOUS: begin
          if (launch_s) res_d[3] = wdata[7:0];
          else          res_d[3] = res_q[3];
        end
        default:    res_d[0] = res_q[0];
      endcase
    end else begin
      res_d[0] = res_q[0];
    end
  end

  // TX FSM: launch snapshots the digits; bytes go out back to back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sel_d   = tx_sel_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    for (int i = 0; i < 5; i++) tx_buf_d[i] = tx_buf_q[i];
    case (tx_state_q)
      TX_IDLE: begin
        if (launch_s) begin
          tx_buf_d[0] = digit_to_ascii(wdata[7:0]);
          tx_buf_d[1] = digit_to_ascii(res_q[2]);
          tx_buf_d[2] = digit_to_ascii(res_q[1]);
          tx_buf_d[3] = digit_to_ascii(res_q[0]);
          tx_buf_d[4] = 8'h0A;
          tx_busy_d   = 1'b1;
          tx_state_d  = TX_START;
          tx_cnt_d    = CNT_ZERO;
          tx_sel_d    = 3'd0;
          tx_d        = 1'b0;
        end else begin
          tx_d        = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = CNT_ZERO;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_buf_q[tx_sel_q][0];
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_buf_q[tx_sel_q][tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_sel_q == 3'd4) begin
            tx_state_d = TX_IDLE;
            tx_busy_d  = 1'b0;
          end else begin
            tx_sel_d   = tx_sel_q + 3'd1;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  // State and register file update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      for (int i = 0; i < FRAME_LEN; i++) rx_byte_q[i] <= 8'h00;
      rx_idx_q   <= IDX_ZERO;
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= 8'h00;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_sel_q   <= 3'd0;
      for (int i = 0; i < 5; i++) tx_buf_q[i] <= 8'h00;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      for (int i = 0; i < FRAME_LEN; i++) rx_byte_q[i] <= rx_byte_d[i];
      rx_idx_q   <= rx_idx_d;
      rx_ready_q <= rx_ready_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sel_q   <= tx_sel_d;
      for (int i = 0; i < 5; i++) tx_buf_q[i] <= tx_buf_d[i];
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Combinational read mux; unaligned and unmapped offsets read zero.
  always_comb begin
    rdata = 32'h0;
    if (sel && (addr[1:0] == 2'b00)) begin
      case (addr)
        ADDR_STATUS: rdata = {29'h0, tx_busy_q, overrun_q, rx_ready_q};
        ADDR_UNITS:  rdata = {24'h0, res_q[0]};
        ADDR_TENS:   rdata = {24'h0, res_q[1]};
        ADDR_HUNDS:  rdata = {24'h0, res_q[2]};
        ADDR_THOUS:  rdata = {24'h0, res_q[3]};
        default: begin
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (addr == 6'(4 * i)) rdata = {24'h0, rx_byte_q[i]};
            else                   rdata = rdata;
          end
        end
      endcase
    end else begin
      rdata = 32'h0;
    end
  end

endmodule
